// File: rtl/m2ft_seq_scale_if.sv
// Operand/result handshake bundle for the sequential meters-to-feet scaler.
interface m2ft_seq_scale_if;
    // A transfer happens on a rising edge where valid & ready are both high;
    // the source keeps data stable while valid is high and ready is low.
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_ovf;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ovf
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ovf
    );
endinterface

// File: rtl/m2ft_seq_scale.sv
// Sequential meters-to-feet scaler for sign-magnitude words, one coefficient bit per cycle.
// Define M2FT_SAT_EN to saturate the magnitude on overflow instead of wrapping.
module m2ft_seq_scale #(
    parameter int                COEF_W = 32,
    parameter logic [COEF_W-1:0] COEF   = 32'd3522775013,
    parameter int                FRAC   = 30
) (
    input  logic             clk,
    input  logic             rst,
    m2ft_seq_scale_if.slave  bus,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(COEF_W);
    localparam int ACC_W = 31 + COEF_W;
    localparam int PRD_W = ACC_W - FRAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               sign_q;
    logic [30:0]        mag_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        out_data_q;
    logic               out_ovf_q;

    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_sum;
    logic [PRD_W-1:0]   prod;
    logic               ovf;
    logic [30:0]        res_mag;
    logic [31:0]        res_data;
    logic               last_step;
    logic               unused_frac;

    assign last_step   = (cnt_q == CNT_W'(COEF_W - 1));
    assign addend      = COEF[cnt_q] ? ({{COEF_W{1'b0}}, mag_q} << cnt_q) : '0;
    assign acc_sum     = acc_q + addend;
    assign prod        = acc_sum[ACC_W-1:FRAC];
    assign unused_frac = ^acc_sum[FRAC-1:0];
    assign ovf         = |prod[PRD_W-1:31];

`ifdef M2FT_SAT_EN
    assign res_mag = ovf ? 31'h7FFF_FFFF : prod[30:0];
`else
    assign res_mag = prod[30:0];
`endif

    // A zero magnitude always leaves with a positive sign.
    assign res_data = {sign_q & (|res_mag), res_mag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q     <= 1'b0;
            mag_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= bus.in_data[31];
                        mag_q  <= bus.in_data[30:0];
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        out_data_q <= res_data;
                        out_ovf_q  <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_m2ft_seq_scale.sv
// Bench for m2ft_seq_scale: directed and random operands against a plain-arithmetic model.
module tb_m2ft_seq_scale;

    localparam longint unsigned COEF_M = 64'd3522775013;
    localparam int              FRAC_M = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    m2ft_seq_scale_if bus ();

    m2ft_seq_scale dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, sign, magnitude} for an operand.
    function automatic logic [32:0] model(input logic [31:0] d);
        longint unsigned p;
        logic            ov;
        logic [30:0]     mag;
        p  = (64'(d[30:0]) * COEF_M) >> FRAC_M;
        ov = (p > 64'h7FFF_FFFF);
        mag = p[30:0];
`ifdef M2FT_SAT_EN
        if (ov) mag = 31'h7FFF_FFFF;
`endif
        return {ov, d[31] && (mag != 31'd0), mag};
    endfunction

    task automatic convert(input logic [31:0] d, input int hold, input bit toggle,
                           output logic [32:0] got);
        int          waitc;
        int          lat;
        logic [31:0] held;
        logic [32:0] exp;
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        waitc = 0;
        while (!bus.in_ready && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("accept_ready", bus.in_ready, 1);
        @(posedge clk);
        exp_q.push_back(model(d));
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        lat = 0;
        do begin
            if (toggle) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = $urandom;
            end
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check("busy_ready", bus.in_ready, 0);
        end while (!bus.out_valid && lat < 100);
        bus.in_valid = 1'b0;
        check("latency", lat, 32);
        held = bus.out_data;
        got  = {bus.out_ovf, bus.out_data};
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_data", bus.out_data, held);
            check("hold_ready", bus.in_ready, 0);
            check("hold_valid", bus.out_valid, 1);
        end
        if (exp_q.size() == 0) begin
            check("queue_empty", 0, 1);
        end else begin
            exp = exp_q.pop_front();
            check("data", bus.out_data, exp[31:0]);
            check("ovf", bus.out_ovf, exp[32]);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_valid", bus.out_valid, 0);
        check("post_ready", bus.in_ready, 1);
    endtask

    task automatic back_to_back();
        logic [31:0] seq [4];
        logic [32:0] exp;
        int          idx_in;
        int          idx_out;
        int          cyc;
        int          ready_run;
        int          last_acc;
        bit          acc;
        seq[0] = 32'd1;
        seq[1] = 32'd2;
        seq[2] = 32'd3;
        seq[3] = 32'h0010_0000;
        idx_in = 0; idx_out = 0; cyc = 0; ready_run = 0; last_acc = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = seq[0];
        while (idx_out < 4 && cyc < 1000) begin
            if (bus.in_ready) ready_run++;
            else ready_run = 0;
            acc = bus.in_ready && bus.in_valid;
            if (acc) begin
                if (idx_in > 0) begin
                    check("b2b_gap", ready_run, 1);
                    check("b2b_period", cyc - last_acc, 34);
                end
                exp_q.push_back(model(bus.in_data));
                last_acc = cyc;
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_queue", 0, 1);
                end else begin
                    exp = exp_q.pop_front();
                    check("b2b_data", bus.out_data, exp[31:0]);
                    check("b2b_ovf", bus.out_ovf, exp[32]);
                    if (idx_out < 3)
                        check("b2b_const", bus.out_data, 32'(3 * (idx_out + 1)));
                end
                idx_out++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                idx_in++;
                if (idx_in < 4) bus.in_data = seq[idx_in];
                else bus.in_valid = 1'b0;
            end
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("b2b_count", idx_out, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] got;
        logic [31:0] d;
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", bus.in_ready, 1);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ovf", bus.out_ovf, 0);
        check("rst_state", dbg_state, 0);

        // Abort a conversion part-way through with an asynchronous reset.
        bus.in_data  = 32'd1000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_ready", bus.in_ready, 1);
        check("midrst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        convert(32'h0000_03E8, 0, 1'b0, got);
        check("pos_const", got, {1'b0, 32'h0000_0CD0});
        convert(32'h8000_03E8, 1, 1'b0, got);
        check("neg_const", got, {1'b0, 32'h8000_0CD0});
        convert(32'h8000_0000, 0, 1'b0, got);
        check("negzero_const", got, 33'd0);
        convert(32'h0000_0000, 0, 1'b0, got);
        check("zero_const", got, 33'd0);
        convert(32'h7FFF_FFFF, 0, 1'b0, got);
        check("ovf_flag", got[32], 1);
`ifdef M2FT_SAT_EN
        check("sat_const", got[31:0], 32'h7FFF_FFFF);
`endif
        convert(32'hFFFF_FFFF, 0, 1'b0, got);
        check("ovf_neg_flag", got[32], 1);
        convert(32'h0012_3456, 10, 1'b0, got);
        convert(32'h0000_03E8, 0, 1'b1, got);
        check("toggle_const", got, {1'b0, 32'h0000_0CD0});

        back_to_back();

        repeat (20) begin
            case ($urandom_range(0, 2))
                0:       d = 32'($urandom_range(0, 2000));
                1:       d = 32'($urandom_range(0, 32'h2700_0000));
                default: d = $urandom;
            endcase
            d[31] = 1'($urandom_range(0, 1));
            convert(d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
